sop_sweep_eval: RTL and testbench

SOP_SWEEP_EVAL -- requirements
Module: sop_sweep_eval

---
 rtl/sop_sweep_eval_if.sv | 36 +++
 rtl/sop_sweep_eval.sv | 112 +++++++++++
 tb/tb_sop_sweep_eval.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/sop_sweep_eval_if.sv
// Signal bundle for sop_sweep_eval: truth-table load, live inputs, sweep control and results.
// The sig field exists only when SOP_SWEEP_SIG_EN is defined.
interface sop_sweep_eval_if #(
  parameter int N_IN = 4
) ();

  logic                    tt_load;
  logic [(1 << N_IN)-1:0]  tt_data;
  logic [N_IN-1:0]         in;
  logic                    start;
  logic                    f;
  logic                    busy;
  logic                    done;
  logic [N_IN-1:0]         sweep_idx;
  logic [N_IN:0]           ones_cnt;
`ifdef SOP_SWEEP_SIG_EN
  logic [7:0]              sig;
`endif

  modport master (
    output tt_load, tt_data, in, start,
    input  f, busy, done, sweep_idx, ones_cnt
`ifdef SOP_SWEEP_SIG_EN
    , input sig
`endif
  );

  modport slave (
    input  tt_load, tt_data, in, start,
    output f, busy, done, sweep_idx, ones_cnt
`ifdef SOP_SWEEP_SIG_EN
    , output sig
`endif
  );

endinterface

// File: rtl/sop_sweep_eval.sv
// Truth-table evaluator of an N_IN-input function with an exhaustive sweep that counts ones.
// Optional macro SOP_SWEEP_SIG_EN adds an 8-bit LFSR-style signature of the swept values.
module sop_sweep_eval #(
  parameter int N_IN = 4
) (
  input  logic               clk,
  input  logic               rst,
  sop_sweep_eval_if.slave    bus
);

  localparam int TT_W = 1 << N_IN;
  localparam logic [N_IN-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [TT_W-1:0]   r_tt;
  logic              r_f;
  logic [N_IN-1:0]   r_sweepIdx;
  logic [N_IN:0]     r_onesCnt;
  logic [N_IN-1:0]   w_idxNext;
  logic              w_accept;
  logic              w_lastIdx;

  // A simultaneous load wins over start, so start is only accepted with tt_load low.
  assign w_accept  = (r_state == IDLE) && bus.start && !bus.tt_load;
  assign w_lastIdx = (r_sweepIdx == LAST_IDX);
  assign w_idxNext = r_sweepIdx + N_IN'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = SWEEP;
      SWEEP:   if (w_lastIdx) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // f always shows the value for the combination being presented: live input or sweep index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tt       <= '0;
      r_f        <= 1'b0;
      r_sweepIdx <= '0;
      r_onesCnt  <= '0;
    end else begin
      if ((r_state == IDLE) && bus.tt_load) begin
        r_tt <= bus.tt_data;
      end
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_sweepIdx <= '0;
            r_onesCnt  <= '0;
            r_f        <= r_tt[0];
          end else begin
            r_f <= r_tt[bus.in];
          end
        end
        SWEEP: begin
          r_onesCnt <= r_onesCnt + (N_IN+1)'(r_f);
          if (w_lastIdx) begin
            r_f <= r_tt[bus.in];
          end else begin
            r_sweepIdx <= w_idxNext;
            r_f        <= r_tt[w_idxNext];
          end
        end
        default: begin
          r_f <= r_tt[bus.in];
        end
      endcase
    end
  end

`ifdef SOP_SWEEP_SIG_EN
  logic [7:0] r_sig;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sig <= 8'h00;
    end else if (w_accept) begin
      r_sig <= 8'h00;
    end else if (r_state == SWEEP) begin
      r_sig <= {r_sig[6:0], 1'b0} ^ (r_sig[7] ? 8'h1D : 8'h00) ^ {7'b0, r_f};
    end
  end

  assign bus.sig = r_sig;
`endif

  assign bus.f         = r_f;
  assign bus.busy      = (r_state == SWEEP);
  assign bus.done      = (r_state == DONE);
  assign bus.sweep_idx = r_sweepIdx;
  assign bus.ones_cnt  = r_onesCnt;

endmodule

// File: tb/tb_sop_sweep_eval.sv
// Self-checking bench for sop_sweep_eval: N_IN=4 instance for the main scenarios, N_IN=2 for the
// parameter check; expectations come from the truth table via plain bit lookups and popcounts.
module tb_sop_sweep_eval;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nChecks = 0;
  int   nErrors = 0;
  logic [15:0] modelTt = '0;

  sop_sweep_eval_if #(.N_IN(4)) busA ();
  sop_sweep_eval_if #(.N_IN(2)) busB ();

  sop_sweep_eval #(.N_IN(4)) dutA (.clk(clk), .rst(rst), .bus(busA));
  sop_sweep_eval #(.N_IN(2)) dutB (.clk(clk), .rst(rst), .bus(busB));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] sigOf(input logic [15:0] t);
    logic [7:0] s = 8'h00;
    for (int k = 0; k < 16; k++) begin
      s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00) ^ {7'b0, t[k]};
    end
    return s;
  endfunction

  task automatic loadTable(input logic [15:0] t);
    busA.tt_load = 1'b1;
    busA.tt_data = t;
    step();
    busA.tt_load = 1'b0;
    modelTt = t;
  endtask

  task automatic applyStimulus(input logic [3:0] v, input string tag);
    busA.in = v;
    step();
    checkOutput(tag, {31'b0, busA.f}, {31'b0, modelTt[v]});
  endtask

  task automatic runSweep(input bit pokeStart, input bit pokeLoad);
    logic [15:0] t;
    int running;
    t = modelTt;
    running = 0;
    busA.start = 1'b1;
    step();
    busA.start = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      checkOutput("sweep_busy", {31'b0, busA.busy}, 32'd1);
      checkOutput("sweep_done_low", {31'b0, busA.done}, 32'd0);
      checkOutput("sweep_idx", {28'b0, busA.sweep_idx}, k - 1);
      checkOutput("sweep_f", {31'b0, busA.f}, {31'b0, t[k-1]});
      checkOutput("sweep_ones_partial", {27'b0, busA.ones_cnt}, running);
      running += t[k-1];
      if (pokeStart && k == 5) busA.start = 1'b1;
      if (pokeLoad && k == 3) begin
        busA.tt_load = 1'b1;
        busA.tt_data = ~t;
      end
      step();
      busA.start   = 1'b0;
      busA.tt_load = 1'b0;
    end
    checkOutput("done_pulse", {31'b0, busA.done}, 32'd1);
    checkOutput("done_busy_low", {31'b0, busA.busy}, 32'd0);
    checkOutput("done_ones_cnt", {27'b0, busA.ones_cnt}, $countones(t));
    checkOutput("done_idx", {28'b0, busA.sweep_idx}, 32'd15);
`ifdef SOP_SWEEP_SIG_EN
    checkOutput("done_sig", {24'b0, busA.sig}, {24'b0, sigOf(t)});
`endif
    step();
    checkOutput("after_done_low", {31'b0, busA.done}, 32'd0);
    checkOutput("after_ones_hold", {27'b0, busA.ones_cnt}, $countones(t));
    checkOutput("after_idx_hold", {28'b0, busA.sweep_idx}, 32'd15);
  endtask

  initial begin
    int cycles;
    logic [15:0] rt;
    busA.tt_load = 1'b0; busA.tt_data = '0; busA.in = '0; busA.start = 1'b0;
    busB.tt_load = 1'b0; busB.tt_data = '0; busB.in = '0; busB.start = 1'b0;

    #3;
    checkOutput("reset_f", {31'b0, busA.f}, 32'd0);
    checkOutput("reset_busy", {31'b0, busA.busy}, 32'd0);
    checkOutput("reset_done", {31'b0, busA.done}, 32'd0);
    checkOutput("reset_idx", {28'b0, busA.sweep_idx}, 32'd0);
    checkOutput("reset_ones", {27'b0, busA.ones_cnt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Directed normal evaluation, then random tables and inputs.
    loadTable(16'h8001);
    applyStimulus(4'd0, "eval_in0");
    applyStimulus(4'd15, "eval_in15");
    applyStimulus(4'd5, "eval_in5");
    checkOutput("eval_busy_low", {31'b0, busA.busy}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      loadTable(16'($urandom));
      for (int j = 0; j < 6; j++) applyStimulus(4'($urandom_range(0, 15)), "eval_rand");
    end

    loadTable(16'h8001);
    runSweep(1'b0, 1'b0);
    loadTable(16'hFFFF);
    runSweep(1'b0, 1'b0);
    loadTable(16'h0000);
    runSweep(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      loadTable(16'($urandom));
      runSweep(1'b0, 1'b0);
    end

    // Requests that must be ignored while sweeping.
    loadTable(16'h5A3C);
    runSweep(1'b1, 1'b1);
    for (int v = 0; v < 16; v += 3) applyStimulus(4'(v), "readback_after_load_in_sweep");

    busA.tt_load = 1'b1;
    busA.start   = 1'b1;
    busA.tt_data = 16'h1234;
    step();
    busA.tt_load = 1'b0;
    busA.start   = 1'b0;
    modelTt = 16'h1234;
    checkOutput("load_start_busy", {31'b0, busA.busy}, 32'd0);
    step();
    checkOutput("load_start_busy2", {31'b0, busA.busy}, 32'd0);
    applyStimulus(4'd2, "load_start_readback2");
    applyStimulus(4'd3, "load_start_readback3");

    // Reset in sweep cycle 8 aborts immediately with no done.
    loadTable(16'hF0F0);
    busA.start = 1'b1;
    step();
    busA.start = 1'b0;
    for (int k = 1; k < 8; k++) step();
    checkOutput("pre_reset_idx", {28'b0, busA.sweep_idx}, 32'd7);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_f", {31'b0, busA.f}, 32'd0);
    checkOutput("rst_busy", {31'b0, busA.busy}, 32'd0);
    checkOutput("rst_done", {31'b0, busA.done}, 32'd0);
    checkOutput("rst_idx", {28'b0, busA.sweep_idx}, 32'd0);
    checkOutput("rst_ones", {27'b0, busA.ones_cnt}, 32'd0);
`ifdef SOP_SWEEP_SIG_EN
    checkOutput("rst_sig", {24'b0, busA.sig}, 32'd0);
`endif
    step();
    @(negedge clk);
    rst = 1'b0;
    modelTt = 16'h0000;
    for (int k = 0; k < 20; k++) begin
      step();
      checkOutput("post_rst_no_done", {31'b0, busA.done}, 32'd0);
      checkOutput("post_rst_idle", {31'b0, busA.busy}, 32'd0);
    end
    applyStimulus(4'd4, "post_rst_tt_cleared");
    loadTable(16'hF0F0);
    runSweep(1'b0, 1'b0);

    // Small instance: N_IN=2, table 4'b0110.
    busB.tt_load = 1'b1;
    busB.tt_data = 4'b0110;
    step();
    busB.tt_load = 1'b0;
    busB.start   = 1'b1;
    step();
    busB.start = 1'b0;
    cycles = 1;
    while (busB.done !== 1'b1 && cycles < 20) begin
      step();
      cycles++;
    end
    checkOutput("n2_done_cycle", cycles, 32'd5);
    checkOutput("n2_ones_cnt", {29'b0, busB.ones_cnt}, 32'd2);
    checkOutput("n2_busy_low", {31'b0, busB.busy}, 32'd0);

    rt = 16'h0;
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
